// File: rtl/draw_pkg.sv
// Shared definitions for the draw-port arbiter: FSM encoding and default geometry.
package draw_pkg;

    localparam int X_MAX_DEF  = 320;
    localparam int Y_MAX_DEF  = 240;
    localparam int ADDR_W_DEF = 17;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        SCAN  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/draw_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic found;

    // Walk the requesters starting from the pointer; the first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[(int'(rr_ptr) + i) % NUM_REQ]) begin
                found                                = 1'b1;
                gnt[(int'(rr_ptr) + i) % NUM_REQ]    = 1'b1;
                idx                                  = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/draw_arbiter.sv
// Arbitrates the VGA pixel port / sprite-ROM address bus among NUM_REQ draw
// requesters, raster-scans the owner's region and aligns x/y/plot to ROM data.
module draw_arbiter
    import draw_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int X_MAX   = X_MAX_DEF,
    parameter int Y_MAX   = Y_MAX_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int ROM_LAT = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       y_start,
    input  logic                       abort,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] sel,
    output logic [ADDR_W-1:0]          addr,
    output logic [8:0]                 x,
    output logic [7:0]                 y,
    output logic                       plot,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy
);

    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int FL_W  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    if (NUM_REQ < 2 || ROM_LAT < 1 || X_MAX > 512 || Y_MAX > 256 ||
        X_MAX * Y_MAX > (1 << ADDR_W)) begin : g_param_chk
        $error("draw_arbiter: illegal parameter combination");
    end

    state_e                   state_q, state_d;
    logic [NUM_REQ-1:0]       grant_q, grant_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic [SEL_W-1:0]         rr_q, rr_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [8:0]               cx_q, cx_d;
    logic [7:0]               cy_q, cy_d;
    logic [FL_W-1:0]          flush_cnt_q, flush_cnt_d;

    // Alignment pipe: stage 0 takes the live scan position, last stage drives VGA.
    logic [ROM_LAT-1:0][8:0]  x_pipe_q, x_pipe_d;
    logic [ROM_LAT-1:0][7:0]  y_pipe_q, y_pipe_d;
    logic [ROM_LAT-1:0]       vld_pipe_q, vld_pipe_d;

    logic [NUM_REQ-1:0][7:0]  ys_a;
    logic [NUM_REQ-1:0]       pick_gnt;
    logic [SEL_W-1:0]         pick_idx;
    logic [SEL_W-1:0]         rr_next;
    logic                     strobe;
    logic                     kill;

    assign ys_a    = y_start;
    assign rr_next = SEL_W'((int'(sel_q) + 1) % NUM_REQ);
    assign strobe  = (state_q == SCAN);
    assign kill    = abort && (state_q == GRANT || state_q == SCAN || state_q == FLUSH);

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (req),
        .rr_ptr (rr_q),
        .gnt    (pick_gnt),
        .idx    (pick_idx)
    );

    // Arbitration FSM and raster counters.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        rr_d        = rr_q;
        addr_d      = addr_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    // Owner and first row are captured here, so GRANT sees them registered.
                    state_d = GRANT;
                    grant_d = pick_gnt;
                    sel_d   = pick_idx;
                    addr_d  = '0;
                    cx_d    = '0;
                    cy_d    = ys_a[pick_idx];
                end
            end
            GRANT: begin
                state_d = (int'(cy_q) >= Y_MAX) ? DONE : SCAN;
            end
            SCAN: begin
                if (cx_q == 9'(X_MAX - 1) && cy_q == 8'(Y_MAX - 1)) begin
                    // Last pixel: hold counters and address so addr ends at count-1.
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (cx_q == 9'(X_MAX - 1)) begin
                        cx_d = '0;
                        cy_d = cy_q + 8'd1;
                    end else begin
                        cx_d = cx_q + 9'd1;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q == FL_W'(ROM_LAT - 1)) state_d = DONE;
                else                                   flush_cnt_d = flush_cnt_q + FL_W'(1);
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                rr_d    = rr_next;
            end
            default: state_d = IDLE;
        endcase
        // Abort drops the port without a done pulse but still rotates priority.
        if (kill) begin
            state_d = IDLE;
            grant_d = '0;
            rr_d    = rr_next;
        end
    end

    // Alignment pipe shift; abort flushes it so nothing stale gets plotted.
    always_comb begin
        x_pipe_d   = x_pipe_q;
        y_pipe_d   = y_pipe_q;
        vld_pipe_d = vld_pipe_q;
        if (kill) begin
            x_pipe_d   = '0;
            y_pipe_d   = '0;
            vld_pipe_d = '0;
        end else begin
            x_pipe_d[0]   = cx_q;
            y_pipe_d[0]   = cy_q;
            vld_pipe_d[0] = strobe;
            for (int i = 1; i < ROM_LAT; i++) begin
                x_pipe_d[i]   = x_pipe_q[i-1];
                y_pipe_d[i]   = y_pipe_q[i-1];
                vld_pipe_d[i] = vld_pipe_q[i-1];
            end
        end
    end

    // Control and counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            sel_q       <= '0;
            rr_q        <= '0;
            addr_q      <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            rr_q        <= rr_d;
            addr_q      <= addr_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Alignment pipe registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_pipe_q   <= '0;
            y_pipe_q   <= '0;
            vld_pipe_q <= '0;
        end else begin
            x_pipe_q   <= x_pipe_d;
            y_pipe_q   <= y_pipe_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign addr  = addr_q;
    assign x     = x_pipe_q[ROM_LAT-1];
    assign y     = y_pipe_q[ROM_LAT-1];
    assign plot  = vld_pipe_q[ROM_LAT-1];
    assign done  = (state_q == DONE) ? grant_q : '0;
    assign busy  = (state_q != IDLE);

endmodule
